// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared definitions for the vending payout path: default amount
//            width, coin values and the change dispenser state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

  // Default width of amount / paid / owed fields (value-1 units)
  localparam int AMT_W_DEF = 3;

  // Face values of the two hopper coin types
  localparam int COIN1_VAL = 1;
  localparam int COIN2_VAL = 2;

  // Change dispenser state encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_FIRE     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4
  } disp_state_e;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/dispense_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : dispense_watchdog
// Purpose  : Per-coin watchdog shared by both hoppers. Counts cycles while
//            run is high; expired pulses on the TIMEOUT_CYC-th such cycle.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            clr           - restart the count (issued when a coin is fired)
//            run           - waiting for a drop this cycle
//            expired       - high on the cycle the wait limit is reached
// Revision : 1.0 - initial release
// ============================================================================
module dispense_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // cnt_q holds the number of earlier waiting cycles, so the current cycle is
  // number cnt_q+1; the limit is therefore hit when cnt_q == TIMEOUT_CYC-1.
  assign expired = run && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : dispense_watchdog
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Pays out a change/refund amount coin by coin through a value-1
//            and a value-2 hopper, with a per-coin drop watchdog, sticky jam
//            flags and a paid/owed report at completion.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            req_valid/req_amt/req_ready - payout request handshake
//            hopN_empty               - hopper empty levels
//            hopN_fire                - one-cycle eject pulses
//            hopN_drop                - coin-drop sensor pulses
//            done                     - one-cycle completion pulse
//            paid, owed               - result, held until next accept
//            hop_jam                  - sticky jam flags {hopper2, hopper1}
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W       = AMT_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  input  logic             hop1_empty,
  input  logic             hop2_empty,
  output logic             hop1_fire,
  output logic             hop2_fire,
  input  logic             hop1_drop,
  input  logic             hop2_drop,
  output logic             done,
  output logic [AMT_W-1:0] paid,
  output logic [AMT_W-1:0] owed,
  output logic [1:0]       hop_jam
);

  localparam logic [AMT_W-1:0] C1 = AMT_W'(COIN1_VAL);
  localparam logic [AMT_W-1:0] C2 = AMT_W'(COIN2_VAL);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] paid_q, paid_d;
  logic [AMT_W-1:0] owed_q, owed_d;
  logic             sel2_q, sel2_d;   // 1: hopper2 selected, 0: hopper1
  logic [1:0]       jam_q, jam_d;
  logic             fire1_q, fire1_d;
  logic             fire2_q, fire2_d;
  logic             done_q, done_d;

  logic             use1, use2;
  logic             drop_sel;
  logic [AMT_W-1:0] coin_val;
  logic             wd_clr, wd_run, wd_expired;

  assign use1     = !hop1_empty && !jam_q[0];
  assign use2     = !hop2_empty && !jam_q[1];
  // Only the selected hopper's sensor is listened to; the other is ignored.
  assign drop_sel = sel2_q ? hop2_drop : hop1_drop;
  assign coin_val = sel2_q ? C2 : C1;
  assign wd_run   = (state_q == ST_WAIT_ACK) && !drop_sel;

  dispense_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .run    (wd_run),
    .expired(wd_expired)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    paid_d  = paid_q;
    owed_d  = owed_q;
    sel2_d  = sel2_q;
    jam_d   = jam_q;
    fire1_d = 1'b0;
    fire2_d = 1'b0;
    done_d  = 1'b0;
    wd_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rem_d  = req_amt;
          paid_d = '0;
          owed_d = '0;
          if (req_amt == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SELECT;
          end
        end
      end
      ST_SELECT: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (rem_q >= C2 && use2) begin
          sel2_d  = 1'b1;
          fire2_d = 1'b1;
          state_d = ST_FIRE;
        end else if (use1) begin
          sel2_d  = 1'b0;
          fire1_d = 1'b1;
          state_d = ST_FIRE;
        end else begin
          owed_d  = rem_q;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_FIRE: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (drop_sel) begin
          rem_d   = rem_q - coin_val;
          paid_d  = paid_q + coin_val;
          state_d = ST_SELECT;
        end else if (wd_expired) begin
          // Jammed: nothing credited; SELECT retries with the other hopper.
          jam_d[sel2_q] = 1'b1;
          state_d       = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      paid_q  <= '0;
      owed_q  <= '0;
      sel2_q  <= 1'b0;
      jam_q   <= 2'b00;
      fire1_q <= 1'b0;
      fire2_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      paid_q  <= paid_d;
      owed_q  <= owed_d;
      sel2_q  <= sel2_d;
      jam_q   <= jam_d;
      fire1_q <= fire1_d;
      fire2_q <= fire2_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign hop1_fire = fire1_q;
  assign hop2_fire = fire2_q;
  assign done      = done_q;
  assign paid      = paid_q;
  assign owed      = owed_q;
  assign hop_jam   = jam_q;

endmodule : change_dispenser
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Self-checking bench for change_dispenser: directed vector table,
//            reset-in-flight sequence and randomized payouts against a
//            coin-counting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_amt;
  logic       req_ready;
  logic       hop1_empty, hop2_empty;
  logic       hop1_fire, hop2_fire;
  logic       hop1_drop, hop2_drop;
  logic       done;
  logic [2:0] paid, owed;
  logic [1:0] hop_jam;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit m_jam1, m_jam2;

  change_dispenser #(.AMT_W(3), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_amt(req_amt), .req_ready(req_ready),
    .hop1_empty(hop1_empty), .hop2_empty(hop2_empty),
    .hop1_fire(hop1_fire), .hop2_fire(hop2_fire),
    .hop1_drop(hop1_drop), .hop2_drop(hop2_drop),
    .done(done), .paid(paid), .owed(owed), .hop_jam(hop_jam)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int amt; bit e1; bit e2; int d1; int d2;   // d = drop delay, 0 = never
    bit busy; bit stray; bit do_rst;
    int x_paid; int x_owed; int x_f1; int x_f2; int x_jam; int x_lat;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid = 1'b0; req_amt = '0;
    hop1_empty = 1'b0; hop2_empty = 1'b0; hop1_drop = 1'b0; hop2_drop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_jam1 = 1'b0; m_jam2 = 1'b0;
  endtask

  // Reference: walk the payout coin by coin; each attempt costs 2 cycles plus
  // the drop delay, or 2+16 if the hopper never drops (and it becomes jammed).
  task automatic model(input int amt, input bit e1, e2, input int d1, d2,
                       output int mp, mo, mf1, mf2, mlat);
    int rem = amt;
    int t = 0;
    mp = 0; mo = 0; mf1 = 0; mf2 = 0;
    while (rem > 0) begin
      if (rem >= 2 && !e2 && !m_jam2) begin
        mf2++;
        if (d2 == 0) begin m_jam2 = 1'b1; t += 18; end
        else begin rem -= 2; mp += 2; t += 2 + d2; end
      end else if (!e1 && !m_jam1) begin
        mf1++;
        if (d1 == 0) begin m_jam1 = 1'b1; t += 18; end
        else begin rem -= 1; mp += 1; t += 2 + d1; end
      end else begin
        mo = rem;
        rem = 0;
      end
    end
    mlat = (amt == 0) ? 1 : t + 2;
  endtask

  // Issue one request and act as the hoppers until done (bounded).
  task automatic run_payout(input int amt, input bit e1, e2, input int d1, d2,
                            input bit busy, stray,
                            output int p, o, f1, f2, lat, output bit got);
    int n, at1, at2, s1;
    check("ready_before_req", int'(req_ready), 1);
    req_valid = 1'b1; req_amt = 3'(amt);
    hop1_empty = e1; hop2_empty = e2;
    n = cyc; at1 = -1; at2 = -1; s1 = -1;
    p = 0; o = 0; f1 = 0; f2 = 0; lat = 0; got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(posedge clk); #1;
      if (busy) begin req_valid = 1'b1; req_amt = 3'($urandom_range(7)); end
      else req_valid = 1'b0;
      if (hop1_fire) begin f1++; if (d1 != 0) at1 = cyc + d1; end
      if (hop2_fire) begin f2++; if (d2 != 0) at2 = cyc + d2; if (stray) s1 = cyc + 1; end
      if (done) begin got = 1'b1; p = int'(paid); o = int'(owed); lat = cyc - n; req_valid = 1'b0; end
      hop1_drop = (cyc == at1) || (cyc == s1);
      hop2_drop = (cyc == at2);
    end
    hop1_drop = 1'b0; hop2_drop = 1'b0;
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic after_done(input int xp, input int xo);
    @(posedge clk); #1;
    check("held_paid", int'(paid), xp);
    check("held_owed", int'(owed), xo);
    check("idle_ready", int'(req_ready), 1);
    check("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    int p, o, f1, f2, lat, mp, mo, mf1, mf2, mlat, amt, d1, d2, cnt_done, cnt_fire;
    bit got, e1, e2;

    //         amt e1 e2 d1 d2 busy stray rst  paid owed f1 f2 jam lat
    vt[0] = '{3, 0, 0, 2, 2, 0, 0, 1,  3, 0, 1, 1, 0, 10};  // mixed payout
    vt[1] = '{4, 0, 1, 2, 2, 0, 0, 1,  4, 0, 4, 0, 0, 18};  // hopper2 empty
    vt[2] = '{3, 1, 1, 2, 2, 0, 0, 1,  0, 3, 0, 0, 0, 2};   // total shortfall
    vt[3] = '{3, 1, 0, 2, 2, 0, 0, 1,  2, 1, 0, 1, 0, 6};   // partial shortfall
    vt[4] = '{0, 0, 0, 2, 2, 0, 0, 1,  0, 0, 0, 0, 0, 1};   // zero request
    vt[5] = '{3, 0, 0, 3, 3, 1, 0, 1,  3, 0, 1, 1, 0, 12};  // busy req_valid
    vt[6] = '{2, 0, 0, 2, 4, 0, 1, 1,  2, 0, 0, 1, 0, 8};   // stray hop1_drop
    vt[7] = '{5, 0, 0, 2, 0, 0, 0, 1,  5, 0, 5, 1, 2, 40};  // jam fallback
    vt[8] = '{2, 0, 0, 1, 2, 0, 0, 0,  2, 0, 2, 0, 2, 8};   // jam is sticky

    reset_dut();
    check("rst_ready", int'(req_ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_fire1", int'(hop1_fire), 0);
    check("rst_fire2", int'(hop2_fire), 0);
    check("rst_paid", int'(paid), 0);
    check("rst_owed", int'(owed), 0);
    check("rst_jam", int'(hop_jam), 0);

    for (int i = 0; i < 9; i++) begin
      if (vt[i].do_rst) reset_dut();
      run_payout(vt[i].amt, vt[i].e1, vt[i].e2, vt[i].d1, vt[i].d2,
                 vt[i].busy, vt[i].stray, p, o, f1, f2, lat, got);
      if (got) begin
        check($sformatf("v%0d_paid", i), p, vt[i].x_paid);
        check($sformatf("v%0d_owed", i), o, vt[i].x_owed);
        check($sformatf("v%0d_fire1", i), f1, vt[i].x_f1);
        check($sformatf("v%0d_fire2", i), f2, vt[i].x_f2);
        check($sformatf("v%0d_latency", i), lat, vt[i].x_lat);
        check($sformatf("v%0d_jam", i), int'(hop_jam), vt[i].x_jam);
        after_done(vt[i].x_paid, vt[i].x_owed);
      end
    end

    // Reset while waiting for a hopper1 drop (hopper2 is still jammed).
    check("pre_rst_jam", int'(hop_jam), 2);
    req_valid = 1'b1; req_amt = 3'd3;
    hop1_empty = 1'b0; hop2_empty = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    cnt_fire = 0;
    for (int k = 0; k < 10 && cnt_fire == 0; k++) begin
      @(posedge clk); #1;
      if (hop1_fire) cnt_fire++;
    end
    check("rst_seq_fire1", cnt_fire, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_ready", int'(req_ready), 1);
    check("midrst_jam", int'(hop_jam), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_paid", int'(paid), 0);
    hop1_drop = 1'b1;                       // late drop from the aborted coin
    @(posedge clk); #1 hop1_drop = 1'b0;
    cnt_done = 0; cnt_fire = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) cnt_done++;
      if (hop1_fire || hop2_fire) cnt_fire++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", cnt_done, 0);
    check("midrst_no_fire", cnt_fire, 0);
    check("midrst_paid_after", int'(paid), 0);

    // Randomized payouts against the reference model.
    reset_dut();
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(3) == 0) reset_dut();
      amt = $urandom_range(7);
      e1  = ($urandom_range(3) == 0);
      e2  = ($urandom_range(3) == 0);
      d1  = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 6);
      d2  = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 6);
      model(amt, e1, e2, d1, d2, mp, mo, mf1, mf2, mlat);
      run_payout(amt, e1, e2, d1, d2, 1'b0, 1'b0, p, o, f1, f2, lat, got);
      if (got) begin
        check($sformatf("r%0d_paid", t), p, mp);
        check($sformatf("r%0d_owed", t), o, mo);
        check($sformatf("r%0d_fire1", t), f1, mf1);
        check($sformatf("r%0d_fire2", t), f2, mf2);
        check($sformatf("r%0d_latency", t), lat, mlat);
        check($sformatf("r%0d_jam", t), int'(hop_jam), {30'd0, m_jam2, m_jam1});
        check($sformatf("r%0d_sum", t), p + o, amt);
        after_done(mp, mo);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_change_dispenser
`default_nettype wire
